count_capture_fifo: RTL and testbench

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

---
 rtl/count_capture_fifo.sv | 138 +++++++++++++
 tb/tb_count_capture_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - snapshot FIFO for a free-running counter with wrap tagging
//
// Purpose:
//   Captures count_in on request and stores it in a small FIFO.
//   Each stored entry is {wrap_flag, count}. wrap_flag is set when the
//   upstream counter has wrapped (all-ones -> 0) since the previous
//   accepted capture, or when it wraps in the capture cycle itself.
//   Captures that arrive while the FIFO is full and not popping are rejected.
//   They are counted in a saturating 8-bit counter.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous active-low reset
//   count_in   - running count from the upstream counter (CW bits)
//   capture    - snapshot request, sampled every cycle
//   out_ready  - downstream consumer ready
//   out_valid  - out_data holds the FIFO head entry
//   out_data   - head entry {wrap_flag, count}; reads 0 when empty
//   level      - number of stored entries
//   full       - level == DEPTH
//   empty      - level == 0
//   dropped    - saturating count of rejected captures

module count_capture_fifo #(
    parameter int CW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CW-1:0]            count_in,
    input  logic                     capture,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CW:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [CW:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    dropped_q, dropped_d;
    logic [CW-1:0] prev_count_q;
    logic          wrap_sticky_q, wrap_sticky_d;

    logic          full_w;
    logic          empty_w;
    logic          wrap_now;
    logic          pop;
    logic          push;
    logic          reject;
    logic [CW:0]   push_entry;

    // Status is derived purely from registered level, so it always
    // reflects the state after the most recent edge (or reset).
    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);

    assign wrap_now   = (prev_count_q == {CW{1'b1}}) && (count_in == '0);
    assign pop        = !empty_w && out_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push       = capture && (!full_w || pop);
    assign reject     = capture && full_w && !pop;
    assign push_entry = {wrap_sticky_q | wrap_now, count_in};

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        dropped_d     = dropped_q;
        wrap_sticky_d = wrap_sticky_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (reject && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end

        // An accepted push consumes the pending flag, including a wrap
        // seen in that same cycle, because the flag is carried in the entry.
        if (push) begin
            wrap_sticky_d = 1'b0;
        end else if (wrap_now) begin
            wrap_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            dropped_q     <= '0;
            prev_count_q  <= '0;
            wrap_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            dropped_q     <= dropped_d;
            prev_count_q  <= count_in;
            wrap_sticky_q <= wrap_sticky_d;
        end
    end

    // Storage needs no reset: out_data is masked while empty, and
    // resetting the pointers makes every stored entry unreachable.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign out_valid = !empty_w;
    assign out_data  = empty_w ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - directed self-checking bench for count_capture_fifo

module tb_count_capture_fifo;

    logic       clock;
    logic       reset;
    logic [5:0] count_in;
    logic       capture;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] out_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic [7:0] dropped;

    int n_checks = 0;
    int n_fail   = 0;

    count_capture_fifo #(.CW(6), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .dropped   (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [5:0] c);
        count_in = c;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; count_in = '0; capture = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 7'h00 || level !== 3'd0 ||
            full !== 1'b0 || empty !== 1'b1 || dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h level=%0d full=%b empty=%b dropped=%0d, required 0 00 0 0 1 0",
                     out_valid, out_data, level, full, empty, dropped);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: valid=%b empty=%b, required 0 1", out_valid, empty);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        push_one(6'd5);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 7'h05 || level !== 3'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL latency: valid=%b data=%h level=%0d empty=%b, required 1 05 1 0",
                     out_valid, out_data, level, empty);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 7'h00) begin
            n_fail++;
            $display("FAIL latency_drain: empty=%b valid=%b data=%h, required 1 0 00",
                     empty, out_valid, out_data);
        end
    endtask

    task automatic test_empty_capture_ready();
        // Ready while empty must not pop anything; the capture just lands.
        out_ready = 1'b1;
        push_one(6'd7);
        n_checks++;
        if (level !== 3'd1 || out_data !== 7'h07) begin
            n_fail++;
            $display("FAIL empty_push_only: level=%0d data=%h, required 1 07", level, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(6'(10 + i));
        n_checks++;
        if (full !== 1'b1 || level !== 3'd4 || dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL fill: full=%b level=%0d dropped=%0d, required 1 4 0", full, level, dropped);
        end
        push_one(6'd14);
        push_one(6'd15);
        n_checks++;
        if (full !== 1'b1 || level !== 3'd4 || dropped !== 8'd2) begin
            n_fail++;
            $display("FAIL fill_drop: full=%b level=%0d dropped=%0d, required 1 4 2", full, level, dropped);
        end
        n_checks++;
        if (out_data !== 7'h0A || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL head_hold: valid=%b data=%h, required 1 0a", out_valid, out_data);
        end
    endtask

    task automatic test_drain_order();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 7'(10 + i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: valid=%b data=%h, required 1 %h",
                         i, out_valid, out_data, 7'(10 + i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 7'h00 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b valid=%b data=%h level=%0d, required 1 0 00 0",
                     empty, out_valid, out_data, level);
        end
    endtask

    task automatic test_wrap_flag();
        out_ready = 1'b0;
        count_in = 6'd62; tick();
        count_in = 6'd63; tick();
        count_in = 6'd0;  tick();
        push_one(6'd1);
        push_one(6'd2);
        n_checks++;
        if (level !== 3'd2 || out_data !== 7'h41) begin
            n_fail++;
            $display("FAIL wrap_first: level=%0d data=%h, required 2 41", level, out_data);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== 7'h02) begin
            n_fail++;
            $display("FAIL wrap_cleared: data=%h, required 02", out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_coincide();
        out_ready = 1'b0;
        count_in = 6'd63; tick();
        push_one(6'd0);
        n_checks++;
        if (level !== 3'd1 || out_data !== 7'h40) begin
            n_fail++;
            $display("FAIL wrap_coincide: level=%0d data=%h, required 1 40", level, out_data);
        end
        push_one(6'd1);
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== 7'h01) begin
            n_fail++;
            $display("FAIL wrap_coincide_next: data=%h, required 01", out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_with_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(6'(30 + i));
        count_in = 6'd20; capture = 1'b1; out_ready = 1'b1;
        tick();
        capture = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (level !== 3'd4 || full !== 1'b1 || dropped !== 8'd2 || out_data !== 7'd31) begin
            n_fail++;
            $display("FAIL full_pop: level=%0d full=%b dropped=%0d data=%h, required 4 1 2 1f",
                     level, full, dropped, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [6:0] exp;
            exp = (i == 3) ? 7'd20 : 7'(31 + i);
            n_checks++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL full_pop_order[%0d]: data=%h, required %h", i, out_data, exp);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(6'(40 + i));
        for (int i = 0; i < 5; i++) push_one(6'd44);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 3'd3 || dropped !== 8'd7) begin
            n_fail++;
            $display("FAIL mid_setup: level=%0d dropped=%0d, required 3 7", level, dropped);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 7'h00 || level !== 3'd0 ||
            full !== 1'b0 || empty !== 1'b1 || dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: valid=%b data=%h level=%0d full=%b empty=%b dropped=%0d, required 0 00 0 0 1 0",
                     out_valid, out_data, level, full, empty, dropped);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || level !== 3'd0) begin
                n_fail++;
                $display("FAIL mid_reset_stale[%0d]: valid=%b level=%0d, required 0 0", i, out_valid, level);
            end
        end
        push_one(6'd9);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 7'h09 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_reset_recover: valid=%b data=%h level=%0d, required 1 09 1",
                     out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(6'(50 + i));
        for (int i = 0; i < 260; i++) push_one(6'd55);
        n_checks++;
        if (dropped !== 8'd255 || level !== 3'd4 || out_data !== 7'd50) begin
            n_fail++;
            $display("FAIL saturate: dropped=%0d level=%0d data=%h, required 255 4 32",
                     dropped, level, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_empty_capture_ready();
        test_fill_drop();
        test_drain_order();
        test_wrap_flag();
        test_wrap_coincide();
        test_full_with_pop();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
